raster_gen: RTL and testbench
=============================

RASTER_GEN -- requirements
Module: raster_gen

Interface
REQ-001 Parameter INIT_X, default 10'd300, sprite X published at reset.
REQ-002 Parameter INIT_Y, default 10'd400, sprite Y published at reset.
REQ-003 clk  input  1  pixel clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pos_valid_i  input  1  host offers new sprite position.
REQ-006 pos_x_i  input  10  offered sprite X.
REQ-007 pos_y_i  input  10  offered sprite Y.
REQ-008 pos_ready_o  output  1  pending slot empty; transfer occurs when valid and ready are both high.
REQ-009 sx_o  output  10  horizontal pixel counter, 0..799.
REQ-010 sy_o  output  10  vertical line counter, 0..524.
REQ-011 hsync_o  output  1  horizontal sync, active-low.
REQ-012 vsync_o  output  1  vertical sync, active-low.
REQ-013 de_o  output  1  display enable, high in the active area.
REQ-014 line_o  output  1  one-cycle line-start strobe.
REQ-015 frame_o  output  1  one-cycle frame-start strobe.
REQ-016 sprx_o  output  10  published sprite X, stable for a whole frame.
REQ-017 spry_o  output  10  published sprite Y, stable for a whole frame.
REQ-018 frame_cnt_o  output  16  frame counter; present only under RASTER_FRAME_CNT_EN.

Function
REQ-019 sx_o SHALL increment by 1 each cycle and wrap 799->0; on that wrap, sy_o SHALL increment and wrap 524->0.
REQ-020 Horizontal timing SHALL be: active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-021 Vertical timing SHALL be: active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-022 hsync_o, vsync_o, de_o, line_o and frame_o SHALL be registered and cycle-aligned with the sx_o/sy_o values they describe (zero relative latency).
REQ-023 de_o SHALL be 1 iff sx_o<640 and sy_o<480.
REQ-024 hsync_o SHALL be 0 iff 656<=sx_o<=751; vsync_o SHALL be 0 iff 490<=sy_o<=491.
REQ-025 line_o SHALL be 1 iff sx_o==0 on every line, blanking lines included.
REQ-026 frame_o SHALL be 1 iff sx_o==0 and sy_o==0.
REQ-027 The pending slot SHALL capture pos_x_i/pos_y_i on a transfer; pos_ready_o SHALL be 0 while the slot is full.
REQ-028 On the clock edge where the counters wrap to (0,0), a full slot SHALL be copied to sprx_o/spry_o and emptied, so the new values appear in the same cycle frame_o=1.
REQ-029 A transfer in the frame_o=1 cycle (slot empty) SHALL be published at the following frame, never mid-frame.
REQ-030 sprx_o/spry_o SHALL NOT change on any edge other than the (0,0) wrap.

Reset
REQ-031 While rst=1, the block SHALL hold: sx_o=799, sy_o=524, hsync_o=1, vsync_o=1, de_o=0, line_o=0, frame_o=0, sprx_o=INIT_X, spry_o=INIT_Y, slot empty, pos_ready_o=0.
REQ-032 On the first edge after rst falls, the block SHALL output sx_o=0, sy_o=0, de_o=1, line_o=1, frame_o=1, pos_ready_o=1.
REQ-033 rst asserted mid-frame SHALL discard a pending position and abort the frame with no partial strobe.

Configuration
REQ-034 With RASTER_FRAME_CNT_EN defined, frame_cnt_o SHALL reset to 0 and increment (mod 2^16) on each edge that produces frame_o=1.
REQ-035 The first frame after reset SHALL read frame_cnt_o=1.
REQ-036 Without RASTER_FRAME_CNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-037 Release rst -> first cycle (0,0) with line_o=frame_o=de_o=1; next frame_o exactly 420000 cycles later.
REQ-038 Scan one frame -> hsync_o low 96 cycles per line starting at sx 656; vsync_o low for sy 490-491; de_o high 307200 cycles.
REQ-039 Offer (100,200) at sy=10 -> accepted, pos_ready_o=0; sprx_o/spry_o stay 300/400 until the wrap, then read 100/200 with frame_o.
REQ-040 Hold valid with (5,6) after (100,200) is pending -> not accepted until the publish cycle; published one frame later.
REQ-041 Offer a position in the frame_o=1 cycle -> published at the next frame, not the current one.
REQ-042 Assert rst mid-frame with a position pending -> outputs return to REQ-031 values; the pending position is never published; frame_cnt_o returns to 0.

Source files
------------

// File: rtl/raster_gen.sv
`default_nettype none
// ============================================================================
// Module   : raster_gen
// Purpose  : 800x525 raster timing generator (640x480 active) with a
//            one-deep sprite-position slot that is published only at the
//            frame boundary, so the sprite never moves mid-frame.
// Options  : RASTER_FRAME_CNT_EN -- adds the 16-bit frame_cnt_o port and
//            its frame counter.
// Revision : 1.0  initial release
// ============================================================================
module raster_gen #(
  parameter logic [9:0]  INIT_X   = 10'd300,
  parameter logic [9:0]  INIT_Y   = 10'd400,
  // Raster geometry; the defaults give the standard 640x480 timing.
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pos_valid_i,
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  output logic       pos_ready_o,
  output logic [9:0] sx_o,
  output logic [9:0] sy_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic       line_o,
  output logic       frame_o,
  output logic [9:0] sprx_o,
  output logic [9:0] spry_o
`ifdef RASTER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt_o
`endif
);

  // Decoded geometry boundaries, all at counter width.
  localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  // Raster counters and the timing flags that describe them.
  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;

  // Sprite slot and published sprite position.
  logic       slot_full_q, slot_full_d;
  logic [9:0] slot_x_q, slot_y_q;
  logic [9:0] sprx_q, spry_q;
  logic       ready_q;

  logic       xfer;
  logic       publish;

  // Next raster position: x wraps every line, y advances on the x wrap.
  always_comb begin
    sx_d = sx_q + 10'd1;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
    end
  end

  // Timing flags decoded from the next position so that, once registered,
  // they line up with the counter values they describe.
  always_comb begin
    de_d    = (sx_d < H_ACT_END) && (sy_d < V_ACT_END);
    hsync_d = !((sx_d >= H_SYNC_FIRST) && (sx_d <= H_SYNC_LAST));
    vsync_d = !((sy_d >= V_SYNC_FIRST) && (sy_d <= V_SYNC_LAST));
    line_d  = (sx_d == '0);
    frame_d = (sx_d == '0) && (sy_d == '0);
  end

  // A transfer needs the slot empty; the slot drains only on the edge that
  // moves the raster to (0,0). The two can never coincide because a
  // transfer requires an empty slot and a publish requires a full one.
  assign xfer    = pos_valid_i && ready_q;
  assign publish = frame_d && slot_full_q;

  // Slot occupancy for the next cycle.
  always_comb begin
    slot_full_d = slot_full_q;
    if (publish) begin
      slot_full_d = 1'b0;
    end else if (xfer) begin
      slot_full_d = 1'b1;
    end
  end

  // Raster counters and registered timing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  // Pending slot: capture on transfer; reset discards any pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full_q <= 1'b0;
      slot_x_q    <= '0;
      slot_y_q    <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      if (xfer) begin
        slot_x_q <= pos_x_i;
        slot_y_q <= pos_y_i;
      end
    end
  end

  // Ready is a registered copy of "slot will be empty"; held low in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= !slot_full_d;
    end
  end

  // Published sprite position changes only on the (0,0) wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sprx_q <= INIT_X;
      spry_q <= INIT_Y;
    end else if (publish) begin
      sprx_q <= slot_x_q;
      spry_q <= slot_y_q;
    end
  end

`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter advances on every edge that raises frame_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

  assign pos_ready_o = ready_q;
  assign sx_o        = sx_q;
  assign sy_o        = sy_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign de_o        = de_q;
  assign line_o      = line_q;
  assign frame_o     = frame_q;
  assign sprx_o      = sprx_q;
  assign spry_o      = spry_q;

endmodule
`default_nettype wire

// File: tb/tb_raster_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_gen
// Purpose  : Self-checking bench for raster_gen. A reduced-geometry instance
//            is scanned over many frames against a reference model built
//            from cycle arithmetic; a default-geometry instance is checked
//            over its first lines. Honours RASTER_FRAME_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_raster_gen;

  // Reduced geometry for the main instance.
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;   // 80
  localparam int VT = VA + VF + VS + VB;   // 32
  localparam int FRAME = HT * VT;          // 2560
  localparam logic [9:0] SX_INIT = 10'd123;
  localparam logic [9:0] SY_INIT = 10'd456;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic       rst;
  logic       pos_valid;
  logic [9:0] pos_x, pos_y;
  logic       pos_ready;
  logic [9:0] sx, sy, sprx, spry;
  logic       hsync, vsync, de, line, frame;
`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] fcnt_o;
`endif

  // Default-geometry instance signals
  logic       d_rst;
  logic       d_valid;
  logic [9:0] d_px, d_py;
  logic       d_ready;
  logic [9:0] d_sx, d_sy, d_sprx, d_spry;
  logic       d_hs, d_vs, d_de, d_line, d_frame;
`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] d_fcnt;
`endif

  raster_gen #(
    .INIT_X(SX_INIT), .INIT_Y(SY_INIT),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_dut (
    .clk(clk), .rst(rst),
    .pos_valid_i(pos_valid), .pos_x_i(pos_x), .pos_y_i(pos_y),
    .pos_ready_o(pos_ready),
    .sx_o(sx), .sy_o(sy), .hsync_o(hsync), .vsync_o(vsync), .de_o(de),
    .line_o(line), .frame_o(frame), .sprx_o(sprx), .spry_o(spry)
`ifdef RASTER_FRAME_CNT_EN
    , .frame_cnt_o(fcnt_o)
`endif
  );

  raster_gen u_dflt (
    .clk(clk), .rst(d_rst),
    .pos_valid_i(d_valid), .pos_x_i(d_px), .pos_y_i(d_py),
    .pos_ready_o(d_ready),
    .sx_o(d_sx), .sy_o(d_sy), .hsync_o(d_hs), .vsync_o(d_vs), .de_o(d_de),
    .line_o(d_line), .frame_o(d_frame), .sprx_o(d_sprx), .spry_o(d_spry)
`ifdef RASTER_FRAME_CNT_EN
    , .frame_cnt_o(d_fcnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: t counts cycles since reset release (t=0 is the first
  // (0,0) cycle, -1 means reset outputs are showing).
  int         t = -1;
  bit         pend = 0;
  logic [9:0] pend_x = '0, pend_y = '0;
  logic [9:0] pub_x = SX_INIT, pub_y = SY_INIT;
  int         fcnt = 0;

  function automatic int e_sx();
    return (t < 0) ? HT - 1 : t % HT;
  endfunction
  function automatic int e_sy();
    return (t < 0) ? VT - 1 : (t / HT) % VT;
  endfunction
  function automatic bit e_ready();
    return (t >= 0) && !pend;
  endfunction
  function automatic logic [45:0] e_vec();
    int x, y;
    bit hs, vs, dde, ln, fr;
    x   = e_sx();
    y   = e_sy();
    dde = (t >= 0) && (x < HA) && (y < VA);
    hs  = !((t >= 0) && (x >= HA + HF) && (x < HA + HF + HS));
    vs  = !((t >= 0) && (y >= VA + VF) && (y < VA + VF + VS));
    ln  = (t >= 0) && (x == 0);
    fr  = (t >= 0) && (x == 0) && (y == 0);
    return {10'(x), 10'(y), hs, vs, dde, ln, fr, pub_x, pub_y, e_ready()};
  endfunction

  // Advance one clock, updating the model with what happens on the edge.
  task automatic tick();
    bit xfer;
    @(posedge clk);
    if (rst) begin
      t = -1; pend = 0; pub_x = SX_INIT; pub_y = SY_INIT; fcnt = 0;
    end else begin
      xfer = pos_valid && e_ready();
      t++;
      if (t % FRAME == 0) begin
        fcnt = (fcnt + 1) % 65536;
        if (pend) begin
          pub_x = pend_x; pub_y = pend_y; pend = 0;
        end
      end
      if (xfer) begin
        pend = 1; pend_x = pos_x; pend_y = pos_y;
      end
    end
    @(negedge clk);
  endtask

  // Run up to the next frame-start cycle; returns how many cycles the
  // sprite/ready outputs disagreed with the model along the way.
  task automatic run_to_frame(output int bad);
    bad = 0;
    do begin
      if ({sprx, spry, pos_ready} !== {pub_x, pub_y, e_ready()}) bad++;
      tick();
    end while (t % FRAME != 0);
  endtask

  task automatic test_default_timing();
    int hs_low, hs_first;
    logic [45:0] exp_v, got_v;
    vectors++;
    if ({d_sx, d_sy, d_hs, d_vs, d_de, d_line, d_frame, d_sprx, d_spry, d_ready} !==
        {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd300, 10'd400, 1'b0}) begin
      miscompares++;
      $display("FAIL dflt_reset: got sx=%0d sy=%0d hs=%b de=%b ln=%b fr=%b spr=%0d/%0d rdy=%b, want 799/524 1 0 0 0 300/400 0",
               d_sx, d_sy, d_hs, d_de, d_line, d_frame, d_sprx, d_spry, d_ready);
    end
    hs_low = 0; hs_first = -1;
    d_rst = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      exp_v = {10'(k % 800), 10'(k / 800),
               !((k % 800) >= 656 && (k % 800) <= 751), 1'b1,
               (k % 800) < 640, (k % 800) == 0, k == 0, 10'd300, 10'd400, 1'b1};
      got_v = {d_sx, d_sy, d_hs, d_vs, d_de, d_line, d_frame, d_sprx, d_spry, d_ready};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL dflt_scan k=%0d: got %h want %h", k, got_v, exp_v);
      end
      if (k < 800 && !d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_sx);
      end
    end
    vectors++;
    if (hs_low != 96 || hs_first != 656) begin
      miscompares++;
      $display("FAIL dflt_hsync: low=%0d first=%0d, want 96 at 656", hs_low, hs_first);
    end
    d_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if ({sx, sy, hsync, vsync, de, line, frame, sprx, spry, pos_ready} !==
        {10'(HT - 1), 10'(VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SX_INIT, SY_INIT, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b spr=%0d/%0d rdy=%b",
               sx, sy, hsync, vsync, de, line, frame, sprx, spry, pos_ready);
    end
`ifdef RASTER_FRAME_CNT_EN
    vectors++;
    if (fcnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_fcnt: got %0d want 0", fcnt_o);
    end
`endif
    rst = 1'b0;
    tick();
    vectors++;
    if ({sx, sy, de, line, frame, pos_ready} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL first_cycle: got sx=%0d sy=%0d de=%b ln=%b fr=%b rdy=%b, want 0 0 1 1 1 1",
               sx, sy, de, line, frame, pos_ready);
    end
`ifdef RASTER_FRAME_CNT_EN
    vectors++;
    if (fcnt_o !== 16'd1) begin
      miscompares++;
      $display("FAIL first_fcnt: got %0d want 1", fcnt_o);
    end
`endif
  endtask

  task automatic test_scan();
    int de_cnt, hs_cnt, gap, last_fr;
    logic [45:0] got_v;
    de_cnt = 0; hs_cnt = 0; gap = -1; last_fr = -1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      got_v = {sx, sy, hsync, vsync, de, line, frame, sprx, spry, pos_ready};
      vectors++;
      if (got_v !== e_vec()) begin
        miscompares++;
        $display("FAIL scan t=%0d: got %h want %h", t, got_v, e_vec());
      end
`ifdef RASTER_FRAME_CNT_EN
      vectors++;
      if (fcnt_o !== 16'(fcnt)) begin
        miscompares++;
        $display("FAIL scan_fcnt t=%0d: got %0d want %0d", t, fcnt_o, fcnt);
      end
`endif
      if (t < FRAME) begin
        if (de) de_cnt++;
        if (!hsync && sy == 10'd0) hs_cnt++;
      end
      if (frame) begin
        if (last_fr >= 0 && gap < 0) gap = c - last_fr;
        last_fr = c;
      end
      pos_valid = ($urandom_range(0, 7) == 0);
      pos_x = 10'($urandom_range(0, 1023));
      pos_y = 10'($urandom_range(0, 1023));
      tick();
    end
    pos_valid = 1'b0;
    vectors++;
    if (de_cnt != HA * VA || hs_cnt != HS || gap != FRAME) begin
      miscompares++;
      $display("FAIL scan_counts: de=%0d hs=%0d gap=%0d, want %0d %0d %0d",
               de_cnt, hs_cnt, gap, HA * VA, HS, FRAME);
    end
  endtask

  task automatic test_publish();
    int bad;
    logic [9:0] old_x, old_y;
    run_to_frame(bad);   // flush anything left pending by the scan
    while (!(e_sy() == 10 && e_sx() == 5)) tick();
    old_x = pub_x; old_y = pub_y;
    vectors++;
    if (pos_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pub_ready_before: got %b want 1", pos_ready);
    end
    pos_valid = 1'b1; pos_x = 10'd100; pos_y = 10'd200;
    tick();
    pos_valid = 1'b0;
    vectors++;
    if ({pos_ready, sprx, spry} !== {1'b0, old_x, old_y}) begin
      miscompares++;
      $display("FAIL pub_accept: got rdy=%b spr=%0d/%0d want 0 %0d/%0d", pos_ready, sprx, spry, old_x, old_y);
    end
    run_to_frame(bad);
    vectors++;
    if (bad != 0 || {sprx, spry, frame, pos_ready} !== {10'd100, 10'd200, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL pub_wrap: bad=%0d spr=%0d/%0d fr=%b rdy=%b, want 0 100/200 1 1", bad, sprx, spry, frame, pos_ready);
    end
  endtask

  task automatic test_offer_on_frame();
    int bad;
    pos_valid = 1'b1; pos_x = 10'd9; pos_y = 10'd10;
    tick();
    pos_valid = 1'b0;
    vectors++;
    if ({pos_ready, sprx, spry} !== {1'b0, 10'd100, 10'd200}) begin
      miscompares++;
      $display("FAIL onframe_accept: got rdy=%b spr=%0d/%0d want 0 100/200", pos_ready, sprx, spry);
    end
    run_to_frame(bad);
    vectors++;
    if (bad != 0 || {sprx, spry} !== {10'd9, 10'd10}) begin
      miscompares++;
      $display("FAIL onframe_pub: bad=%0d spr=%0d/%0d want 0 9/10", bad, sprx, spry);
    end
  endtask

  task automatic test_hold_valid();
    int bad, early;
    while (e_sx() != 20) tick();
    pos_valid = 1'b1; pos_x = 10'd100; pos_y = 10'd200;
    tick();
    pos_x = 10'd5; pos_y = 10'd6;
    early = 0;
    while (t % FRAME != 0) begin
      if (pos_ready !== 1'b0 || sprx !== 10'd9) early++;
      tick();
    end
    vectors++;
    if (early != 0 || {sprx, spry, pos_ready} !== {10'd100, 10'd200, 1'b1}) begin
      miscompares++;
      $display("FAIL hold_first: early=%0d spr=%0d/%0d rdy=%b want 0 100/200 1", early, sprx, spry, pos_ready);
    end
    tick();
    pos_valid = 1'b0;
    vectors++;
    if (pos_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_accept: rdy=%b want 0", pos_ready);
    end
    run_to_frame(bad);
    vectors++;
    if (bad != 0 || {sprx, spry} !== {10'd5, 10'd6}) begin
      miscompares++;
      $display("FAIL hold_pub: bad=%0d spr=%0d/%0d want 0 5/6", bad, sprx, spry);
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    while (e_sy() != 12) tick();
    pos_valid = 1'b1; pos_x = 10'd33; pos_y = 10'd44;
    tick();
    pos_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({sx, sy, hsync, vsync, de, line, frame, sprx, spry, pos_ready} !==
        {10'(HT - 1), 10'(VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SX_INIT, SY_INIT, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_state: got sx=%0d sy=%0d ln=%b fr=%b spr=%0d/%0d rdy=%b",
               sx, sy, line, frame, sprx, spry, pos_ready);
    end
`ifdef RASTER_FRAME_CNT_EN
    vectors++;
    if (fcnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL midrst_fcnt: got %0d want 0", fcnt_o);
    end
`endif
    rst = 1'b0;
    tick();
    vectors++;
    if ({sx, sy, frame, line, sprx, spry, pos_ready} !== {10'd0, 10'd0, 1'b1, 1'b1, SX_INIT, SY_INIT, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_release: got sx=%0d sy=%0d fr=%b spr=%0d/%0d rdy=%b", sx, sy, frame, sprx, spry, pos_ready);
    end
    run_to_frame(bad);
    vectors++;
    if (bad != 0 || {sprx, spry} !== {SX_INIT, SY_INIT}) begin
      miscompares++;
      $display("FAIL midrst_discard: bad=%0d spr=%0d/%0d want 0 %0d/%0d", bad, sprx, spry, SX_INIT, SY_INIT);
    end
  endtask

  initial begin
    rst = 1'b1; pos_valid = 1'b0; pos_x = '0; pos_y = '0;
    d_rst = 1'b1; d_valid = 1'b0; d_px = '0; d_py = '0;
    @(negedge clk);
    repeat (3) tick();
    test_default_timing();
    test_reset();
    test_scan();
    test_publish();
    test_offer_on_frame();
    test_hold_valid();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
